fpu_result_checker: RTL and testbench

Synthesizable result checker sitting directly downstream of the FPU, turning the bench's match/rounding/dismatch bookkeeping into on-chip hardware usable in FPGA self-test. The checker queues an expected value each time an operation is issued to the FPU. It compares each FPU result against the oldest queued expectation and classifies it as exact match, rounding error (encodings differ by exactly 1), or dismatch. It also keeps saturating counters of each class.

---
 rtl/fpu_pkg.sv | 13 +
 rtl/fpu_exp_fifo.sv | 43 ++++
 rtl/fpu_result_checker.sv | 99 +++++++++
 tb/tb_fpu_result_checker.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU result checker: word width and class codes.
package fpu_pkg;

    localparam int FP_W = 32;

    typedef enum logic [1:0] {
        CLS_IDLE     = 2'b00,
        CLS_MATCH    = 2'b01,
        CLS_ROUND    = 2'b10,
        CLS_DISMATCH = 2'b11
    } cls_t;

endpackage

// File: rtl/fpu_exp_fifo.sv
// Expected-value queue: power-of-two depth with an extra pointer MSB that separates full from empty.
module fpu_exp_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            push,
    input  logic            pop,
    input  logic [FP_W-1:0] din,
    output logic [FP_W-1:0] head,
    output logic            Empty,
    output logic            Full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [FP_W-1:0] mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;

    assign head  = mem[rd_ptr[AW-1:0]];
    assign Empty = (wr_ptr == rd_ptr);
    assign Full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage carries no reset; only the pointers define which entries are live.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/fpu_result_checker.sv
// Compares each FPU result with the oldest queued expectation, classifies it and
// keeps saturating per-class counts plus sticky overflow/underflow flags.
module fpu_result_checker
    import fpu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Clear,
    input  logic             ExpValid,
    input  logic [FP_W-1:0]  Expected,
    input  logic             ResultValid,
    input  logic [FP_W-1:0]  Result,
    output logic             ClassValid,
    output logic [1:0]       Class,
    output logic [CNT_W-1:0] NumMatched,
    output logic [CNT_W-1:0] NumRounding,
    output logic [CNT_W-1:0] NumDismatch,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Empty,
    output logic             Full
);

    logic            push;
    logic            pop;
    logic [FP_W-1:0] head;
    cls_t            cls_p0;

    function automatic cls_t classify(input logic [FP_W-1:0] res, input logic [FP_W-1:0] exp_val);
        logic [FP_W-1:0] diff;
        diff = res - exp_val;
        if (res == exp_val)
            return CLS_MATCH;
        else if (diff == FP_W'(1) || diff == '1)
            return CLS_ROUND;
        return CLS_DISMATCH;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == '1) ? cnt : cnt + CNT_W'(1);
    endfunction

    // No bypass: a result arriving while empty never sees the same-cycle push.
    assign pop  = ResultValid & ~Empty;
    assign push = ExpValid & (~Full | pop);

    fpu_exp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push),
        .pop   (pop),
        .din   (Expected),
        .head  (head),
        .Empty (Empty),
        .Full  (Full)
    );

    assign cls_p0 = classify(Result, head);

    // p0 -> p1: register the class and update counters/flags
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ClassValid  <= 1'b0;
            Class       <= CLS_IDLE;
            NumMatched  <= '0;
            NumRounding <= '0;
            NumDismatch <= '0;
            Overflow    <= 1'b0;
            Underflow   <= 1'b0;
        end else begin
            ClassValid <= pop;
            Class      <= pop ? cls_p0 : CLS_IDLE;
            if (Clear) begin
                NumMatched  <= '0;
                NumRounding <= '0;
                NumDismatch <= '0;
                Overflow    <= 1'b0;
                Underflow   <= 1'b0;
            end else begin
                if (pop) begin
                    case (cls_p0)
                        CLS_MATCH:    NumMatched  <= sat_inc(NumMatched);
                        CLS_ROUND:    NumRounding <= sat_inc(NumRounding);
                        CLS_DISMATCH: NumDismatch <= sat_inc(NumDismatch);
                        default:      ;
                    endcase
                end
                if (ExpValid & Full & ~pop) Overflow  <= 1'b1;
                if (ResultValid & Empty)    Underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpu_result_checker.sv
// Directed bench for fpu_result_checker with a queue-based reference model checked every cycle.
module tb_fpu_result_checker;

    localparam int DEPTH = 8;
    localparam int CNT_W = 8;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             CLK;
    logic             RST;
    logic             Clear;
    logic             ExpValid;
    logic [31:0]      Expected;
    logic             ResultValid;
    logic [31:0]      Result;
    logic             ClassValid;
    logic [1:0]       Class;
    logic [CNT_W-1:0] NumMatched;
    logic [CNT_W-1:0] NumRounding;
    logic [CNT_W-1:0] NumDismatch;
    logic             Overflow;
    logic             Underflow;
    logic             Empty;
    logic             Full;

    int n_checks = 0;
    int n_fail   = 0;

    fpu_result_checker #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Clear       (Clear),
        .ExpValid    (ExpValid),
        .Expected    (Expected),
        .ResultValid (ResultValid),
        .Result      (Result),
        .ClassValid  (ClassValid),
        .Class       (Class),
        .NumMatched  (NumMatched),
        .NumRounding (NumRounding),
        .NumDismatch (NumDismatch),
        .Overflow    (Overflow),
        .Underflow   (Underflow),
        .Empty       (Empty),
        .Full        (Full)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: state expected to be visible after the next rising edge.
    logic [31:0] q[$];
    int          m_cm, m_cr, m_cd;
    logic        m_ov, m_un, m_cv;
    logic [1:0]  m_cls;

    task automatic model_reset();
        q.delete();
        m_cm = 0; m_cr = 0; m_cd = 0;
        m_ov = 0; m_un = 0; m_cv = 0; m_cls = 2'b00;
    endtask

    task automatic model_step();
        logic [31:0] h;
        logic [31:0] up;
        logic [31:0] dn;
        bit          was_empty;
        bit          was_full;
        bit          popping;
        was_empty = (q.size() == 0);
        was_full  = (q.size() == DEPTH);
        popping   = ResultValid && !was_empty;
        m_cv  = popping;
        m_cls = 2'b00;
        if (popping) begin
            h  = q.pop_front();
            up = h + 32'd1;
            dn = h - 32'd1;
            if (Result == h)                     m_cls = 2'b01;
            else if (Result == up || Result == dn) m_cls = 2'b10;
            else                                 m_cls = 2'b11;
        end
        if (Clear) begin
            m_cm = 0; m_cr = 0; m_cd = 0; m_ov = 0; m_un = 0;
        end else begin
            if (m_cls == 2'b01 && m_cm < MAXC) m_cm++;
            if (m_cls == 2'b10 && m_cr < MAXC) m_cr++;
            if (m_cls == 2'b11 && m_cd < MAXC) m_cd++;
            if (ResultValid && was_empty)            m_un = 1;
            if (ExpValid && was_full && !popping)    m_ov = 1;
        end
        if (ExpValid && (!was_full || popping)) q.push_back(Expected);
    endtask

    // Compare process: check DUT against model at every falling edge, then advance the model.
    initial begin
        model_reset();
        forever begin
            @(negedge CLK);
            if (RST) model_reset();
            chk("ClassValid",  32'(ClassValid),  32'(m_cv));
            chk("Class",       32'(Class),       32'(m_cls));
            chk("NumMatched",  32'(NumMatched),  32'(m_cm));
            chk("NumRounding", 32'(NumRounding), 32'(m_cr));
            chk("NumDismatch", 32'(NumDismatch), 32'(m_cd));
            chk("Overflow",    32'(Overflow),    32'(m_ov));
            chk("Underflow",   32'(Underflow),   32'(m_un));
            chk("Empty",       32'(Empty),       32'(q.size() == 0));
            chk("Full",        32'(Full),        32'(q.size() == DEPTH));
            if (!RST) model_step();
        end
    end

    task automatic cyc(input logic ev, input logic [31:0] e, input logic rv, input logic [31:0] r,
                       input logic clr);
        @(posedge CLK);
        #1;
        ExpValid    = ev;
        Expected    = e;
        ResultValid = rv;
        Result      = r;
        Clear       = clr;
    endtask

    task automatic settle();
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge CLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b1; Clear = 1'b0; ExpValid = 1'b0; Expected = '0; ResultValid = 1'b0; Result = '0;
        repeat (2) @(negedge CLK);
        chk("rst_Empty",      32'(Empty),      32'd1);
        chk("rst_Full",       32'(Full),       32'd0);
        chk("rst_ClassValid", 32'(ClassValid), 32'd0);
        chk("rst_NumMatched", 32'(NumMatched), 32'd0);
        @(posedge CLK); #1; RST = 1'b0;

        // exact match
        cyc(1'b1, 32'h3F800000, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 32'h3F800000, 1'b0);
        settle();
        chk("match_Class", 32'(Class), 32'd1);
        chk("match_Num",   32'(NumMatched), 32'd1);
        chk("match_Empty", 32'(Empty), 32'd1);

        // rounding, both directions and wrap-around
        cyc(1'b1, 32'h40490FDB, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 32'h40490FDC, 1'b0);
        settle();
        chk("round_up_Class", 32'(Class), 32'd2);
        chk("round_up_Num",   32'(NumRounding), 32'd1);
        cyc(1'b1, 32'h40490FDB, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 32'h40490FDA, 1'b0);
        settle();
        chk("round_dn_Num", 32'(NumRounding), 32'd2);
        cyc(1'b1, 32'h00000000, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b0);
        settle();
        chk("round_wrap_Class", 32'(Class), 32'd2);
        chk("round_wrap_Num",   32'(NumRounding), 32'd3);

        // sign flip is a dismatch
        cyc(1'b1, 32'h3F800000, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 32'hBF800000, 1'b0);
        settle();
        chk("dis_Class", 32'(Class), 32'd3);
        chk("dis_Num",   32'(NumDismatch), 32'd1);

        // fill, overflow, push+pop while full, drain
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'h1000 + 32'(i), 1'b0, 32'h0, 1'b0);
        settle();
        chk("fill_Full", 32'(Full), 32'd1);
        cyc(1'b1, 32'h1FFF, 1'b0, 32'h0, 1'b0);
        settle();
        chk("ovf_flag", 32'(Overflow), 32'd1);
        chk("ovf_Full", 32'(Full), 32'd1);
        cyc(1'b1, 32'h2000, 1'b1, 32'h1000, 1'b0);
        settle();
        chk("pp_Full",  32'(Full), 32'd1);
        chk("pp_Class", 32'(Class), 32'd1);
        for (int i = 1; i < DEPTH; i++) cyc(1'b0, 32'h0, 1'b1, 32'h1000 + 32'(i), 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 32'h2000, 1'b0);
        settle();
        chk("drain_Empty",   32'(Empty), 32'd1);
        chk("drain_Matched", 32'(NumMatched), 32'd10);

        // underflow with same-cycle push: no bypass
        cyc(1'b1, 32'h40000000, 1'b1, 32'h40000000, 1'b0);
        settle();
        chk("unf_ClassValid", 32'(ClassValid), 32'd0);
        chk("unf_flag",       32'(Underflow), 32'd1);
        chk("unf_Empty",      32'(Empty), 32'd0);
        cyc(1'b0, 32'h0, 1'b1, 32'h40000000, 1'b0);
        settle();
        chk("unf_next_Class", 32'(Class), 32'd1);
        chk("unf_next_Empty", 32'(Empty), 32'd1);

        // clear, then saturate
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        settle();
        chk("clr_Matched",   32'(NumMatched), 32'd0);
        chk("clr_Overflow",  32'(Overflow), 32'd0);
        chk("clr_Underflow", 32'(Underflow), 32'd0);
        for (int i = 0; i < 300; i++)
            cyc(1'b1, 32'h5000 + 32'(i), (i > 0), 32'h5000 + 32'(i) - 32'd1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 32'h5000 + 32'd299, 1'b0);
        settle();
        chk("sat_Matched", 32'(NumMatched), 32'd255);

        // clear wins over a same-cycle classification
        cyc(1'b1, 32'h7777, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 32'h7777, 1'b1);
        settle();
        chk("clrwin_ClassValid", 32'(ClassValid), 32'd1);
        chk("clrwin_Matched",    32'(NumMatched), 32'd0);

        // reset mid-stream discards queued entries
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h9000 + 32'(i), 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(posedge CLK); #1; RST = 1'b1;
        @(negedge CLK);
        chk("mid_rst_Empty",   32'(Empty), 32'd1);
        chk("mid_rst_Class",   32'(Class), 32'd0);
        chk("mid_rst_Rounding",32'(NumRounding), 32'd0);
        @(posedge CLK); #1; RST = 1'b0;
        cyc(1'b0, 32'h0, 1'b1, 32'h9000, 1'b0);
        settle();
        chk("post_rst_unf", 32'(Underflow), 32'd1);
        chk("post_rst_cv",  32'(ClassValid), 32'd0);

        repeat (2) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
